// File: rtl/rob_commit.sv
// Reorder buffer with dual allocation, writeback completion and in-order dual commit.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer at the next edge.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int TAGW  = 4,
  parameter int AW    = 3,
  parameter int PW    = 4
) (
  input  logic            clk,
  input  logic            reset,
`ifdef ROB_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            V1,
  input  logic            V2,
  input  logic [AW-1:0]   ArD1,
  input  logic [AW-1:0]   ArD2,
  input  logic [PW-1:0]   PrD1,
  input  logic [PW-1:0]   PrD2,
  output logic [TAGW-1:0] Tag1,
  output logic [TAGW-1:0] Tag2,
  output logic            stallRR,
  input  logic            wbValid,
  input  logic [TAGW-1:0] wbTag,
  output logic [1:0]      CmtCount,
  output logic [AW-1:0]   CmtArD1,
  output logic [AW-1:0]   CmtArD2,
  output logic [PW-1:0]   CmtPrD1,
  output logic [PW-1:0]   CmtPrD2,
  output logic            robEmpty,
  output logic [TAGW:0]   robCount
);

  localparam logic [TAGW:0] STALL_AT = (TAGW+1)'(DEPTH - 1);
  localparam logic [TAGW:0] TWO      = (TAGW+1)'(2);

  logic [TAGW-1:0] headReg, tailReg;
  logic [TAGW:0]   countReg, countNext;
  logic [TAGW-1:0] headPlus1, slot2;
  logic [DEPTH-1:0] validVec, doneVec;
  logic [AW-1:0]   arDArr [DEPTH];
  logic [PW-1:0]   prDArr [DEPTH];
  logic            allocV1, allocV2, c0, c1, flushNow;
  logic [1:0]      allocNum, ncmt;

`ifdef ROB_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  // Backpressure uses only registered occupancy, so a same-cycle commit never frees a slot.
  assign stallRR   = (countReg >= STALL_AT);
  assign allocV1   = V1 & ~stallRR;
  assign allocV2   = V2 & ~stallRR;
  assign allocNum  = {1'b0, allocV1} + {1'b0, allocV2};
  assign slot2     = V1 ? tailReg + TAGW'(1) : tailReg;
  assign Tag1      = tailReg;
  assign Tag2      = slot2;
  assign headPlus1 = headReg + TAGW'(1);

  assign c0   = (countReg != '0) && doneVec[headReg];
  assign c1   = c0 && (countReg >= TWO) && doneVec[headPlus1];
  assign ncmt = {1'b0, c0} + {1'b0, c1};

  assign countNext = countReg + (TAGW+1)'(allocNum) - (TAGW+1)'(ncmt);
  assign robEmpty  = (countReg == '0);
  assign robCount  = countReg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      localparam logic [TAGW-1:0] IDX = TAGW'(gi);
      logic validQ, doneQ;
      logic [AW-1:0] arQ;
      logic [PW-1:0] prQ;
      logic wr1, wr2, cmtHit, wbHit;

      assign wr1    = allocV1 && (tailReg == IDX);
      assign wr2    = allocV2 && (slot2 == IDX);
      assign cmtHit = (c0 && (headReg == IDX)) || (c1 && (headPlus1 == IDX));
      assign wbHit  = wbValid && (wbTag == IDX) && validQ;

      // Allocation only targets free slots, so its priority over commit/writeback never masks a live entry.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          validQ <= 1'b0;
          doneQ  <= 1'b0;
          arQ    <= '0;
          prQ    <= '0;
        end else if (flushNow) begin
          validQ <= 1'b0;
          doneQ  <= 1'b0;
        end else if (wr1 || wr2) begin
          validQ <= 1'b1;
          doneQ  <= 1'b0;
          arQ    <= wr1 ? ArD1 : ArD2;
          prQ    <= wr1 ? PrD1 : PrD2;
        end else if (cmtHit) begin
          validQ <= 1'b0;
          doneQ  <= 1'b0;
        end else if (wbHit) begin
          doneQ  <= 1'b1;
        end
      end

      assign validVec[gi] = validQ;
      assign doneVec[gi]  = doneQ;
      assign arDArr[gi]   = arQ;
      assign prDArr[gi]   = prQ;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
      CmtCount <= '0;
      CmtArD1  <= '0;
      CmtArD2  <= '0;
      CmtPrD1  <= '0;
      CmtPrD2  <= '0;
    end else if (flushNow) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
      CmtCount <= '0;
      CmtArD1  <= '0;
      CmtArD2  <= '0;
      CmtPrD1  <= '0;
      CmtPrD2  <= '0;
    end else begin
      headReg  <= headReg + TAGW'(ncmt);
      tailReg  <= tailReg + TAGW'(allocNum);
      countReg <= countNext;
      CmtCount <= ncmt;
      CmtArD1  <= c0 ? arDArr[headReg]   : '0;
      CmtPrD1  <= c0 ? prDArr[headReg]   : '0;
      CmtArD2  <= c1 ? arDArr[headPlus1] : '0;
      CmtPrD2  <= c1 ? prDArr[headPlus1] : '0;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Randomized check of rob_commit against a queue-based program-order model.
// Flush checks are compiled in only when ROB_FLUSH_EN is defined.
module tb_rob_commit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flushSig = 1'b0;
  logic       V1 = 1'b0, V2 = 1'b0;
  logic [2:0] ArD1 = '0, ArD2 = '0;
  logic [3:0] PrD1 = '0, PrD2 = '0;
  logic [3:0] Tag1, Tag2;
  logic       stallRR;
  logic       wbValid = 1'b0;
  logic [3:0] wbTag = '0;
  logic [1:0] CmtCount;
  logic [2:0] CmtArD1, CmtArD2;
  logic [3:0] CmtPrD1, CmtPrD2;
  logic       robEmpty;
  logic [4:0] robCount;

  rob_commit dut (
    .clk(clk), .reset(reset),
`ifdef ROB_FLUSH_EN
    .flush(flushSig),
`endif
    .V1(V1), .V2(V2), .ArD1(ArD1), .ArD2(ArD2), .PrD1(PrD1), .PrD2(PrD2),
    .Tag1(Tag1), .Tag2(Tag2), .stallRR(stallRR),
    .wbValid(wbValid), .wbTag(wbTag),
    .CmtCount(CmtCount), .CmtArD1(CmtArD1), .CmtArD2(CmtArD2),
    .CmtPrD1(CmtPrD1), .CmtPrD2(CmtPrD2),
    .robEmpty(robEmpty), .robCount(robCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [2:0] ar;
    logic [3:0] pr;
    bit         done;
  } ent_t;

  ent_t       q[$];
  logic [3:0] tailTag;
  logic [1:0] eCnt;
  logic [2:0] eAr1, eAr2;
  logic [3:0] ePr1, ePr2;
  int         checks = 0;
  int         errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; model is a program-order queue, commits pop its front.
  task automatic step(input bit v1, input bit v2, input logic [2:0] a1, input logic [2:0] a2,
                      input logic [3:0] p1, input logic [3:0] p2,
                      input bit wv, input logic [3:0] wt, input bit fl);
    bit stall;
    int n;
    logic [3:0] t2;
    V1 = v1; V2 = v2; ArD1 = a1; ArD2 = a2; PrD1 = p1; PrD2 = p2;
    wbValid = wv; wbTag = wt; flushSig = fl;
    #1;
    stall = (q.size() >= 15);
    t2 = v1 ? tailTag + 4'd1 : tailTag;
    checkVal("tag1", 32'(Tag1), 32'(tailTag));
    checkVal("tag2", 32'(Tag2), 32'(t2));
    checkVal("stallRR", 32'(stallRR), 32'(stall));
    checkVal("robCount", 32'(robCount), 32'(q.size()));
    checkVal("robEmpty", 32'(robEmpty), 32'(q.size() == 0));
    n = 0;
    if (q.size() >= 1 && q[0].done) n = 1;
    if (n == 1 && q.size() >= 2 && q[1].done) n = 2;
    eCnt = 2'(n);
    eAr1 = (n >= 1) ? q[0].ar : 3'd0;
    ePr1 = (n >= 1) ? q[0].pr : 4'd0;
    eAr2 = (n == 2) ? q[1].ar : 3'd0;
    ePr2 = (n == 2) ? q[1].pr : 4'd0;
    for (int i = 0; i < n; i++) void'(q.pop_front());
    if (fl) begin
      q.delete();
      tailTag = 4'd0;
      eCnt = 2'd0; eAr1 = 3'd0; eAr2 = 3'd0; ePr1 = 4'd0; ePr2 = 4'd0;
    end else begin
      if (wv) foreach (q[i]) if (q[i].tag == wt) q[i].done = 1'b1;
      if (!stall) begin
        if (v1) begin q.push_back('{tailTag, a1, p1, 1'b0}); tailTag = tailTag + 4'd1; end
        if (v2) begin q.push_back('{tailTag, a2, p2, 1'b0}); tailTag = tailTag + 4'd1; end
      end
    end
    @(posedge clk);
    #1;
    checkVal("CmtCount", 32'(CmtCount), 32'(eCnt));
    checkVal("CmtArD1", 32'(CmtArD1), 32'(eAr1));
    checkVal("CmtPrD1", 32'(CmtPrD1), 32'(ePr1));
    checkVal("CmtArD2", 32'(CmtArD2), 32'(eAr2));
    checkVal("CmtPrD2", 32'(CmtPrD2), 32'(ePr2));
    $display("t=%0t v=%b%b wb=%b:%0d fl=%b cmt=%0d cnt=%0d", $time, v1, v2, wv, wt, fl, CmtCount, robCount);
  endtask

  task automatic idle();
    step(0, 0, 3'd0, 3'd0, 4'd0, 4'd0, 0, 4'd0, 0);
  endtask

  task automatic wb(input logic [3:0] t);
    step(0, 0, 3'd0, 3'd0, 4'd0, 4'd0, 1, t, 0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    V1 = 1'b1; V2 = 1'b0; wbValid = 1'b0; flushSig = 1'b0;
    #2;
    checkVal("rst_robEmpty", 32'(robEmpty), 32'd1);
    checkVal("rst_stallRR", 32'(stallRR), 32'd0);
    checkVal("rst_CmtCount", 32'(CmtCount), 32'd0);
    checkVal("rst_CmtArD1", 32'(CmtArD1), 32'd0);
    checkVal("rst_robCount", 32'(robCount), 32'd0);
    checkVal("rst_Tag1", 32'(Tag1), 32'd0);
    checkVal("rst_Tag2", 32'(Tag2), 32'd1);
    q.delete();
    tailTag = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    V1 = 1'b0;
  endtask

  initial begin
    logic [3:0] t0;
    bit         v1, v2, wv;
    logic [3:0] wt;
    int         pend[$];

    #1;
    doReset();

    // Single allocation, writeback, commit.
    step(1, 0, 3'd3, 3'd0, 4'd9, 4'd0, 0, 4'd0, 0);
    wb(4'd0);
    idle();
    checkVal("t2_CmtArD1", 32'(CmtArD1), 32'd3);
    checkVal("t2_CmtPrD1", 32'(CmtPrD1), 32'd9);
    idle();

    // Out-of-order completion; both retire together in program order.
    t0 = tailTag;
    step(1, 1, 3'd5, 3'd6, 4'd2, 4'd7, 0, 4'd0, 0);
    wb(t0 + 4'd1);
    idle();
    wb(t0);
    idle();
    checkVal("t3_CmtCount", 32'(CmtCount), 32'd2);
    idle();

    // Fill to 15 entries and confirm allocation is blocked.
    t0 = tailTag;
    for (int i = 0; i < 7; i++)
      step(1, 1, 3'(i), 3'(i + 1), 4'(i + 3), 4'(i + 4), 0, 4'd0, 0);
    step(1, 0, 3'd7, 3'd0, 4'd15, 4'd0, 0, 4'd0, 0);
    checkVal("t4_stall", 32'(stallRR), 32'd1);
    step(1, 1, 3'd1, 3'd2, 4'd1, 4'd2, 0, 4'd0, 0);
    wb(t0);
    idle();
    idle();
    checkVal("t4_unstall", 32'(stallRR), 32'd0);

    // Random traffic: wraps pointers many times, includes stray writebacks.
    for (int c = 0; c < 400; c++) begin
      v1 = ($urandom_range(0, 3) != 0);
      v2 = ($urandom_range(0, 2) != 0);
      wv = ($urandom_range(0, 4) != 0);
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(int'(q[i].tag));
      if (pend.size() != 0 && $urandom_range(0, 3) != 0)
        wt = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wt = 4'($urandom_range(0, 15));
      step(v1, v2, 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), wv, wt, 0);
    end

    // Reset in the middle of traffic.
    doReset();
    idle();

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 3; i++)
      step(1, 1, 3'(i), 3'(i + 2), 4'(i + 5), 4'(i + 1), 0, 4'd0, 0);
    wb(4'd0);
    checkVal("fl_live", 32'(robCount), 32'd6);
    step(1, 1, 3'd1, 3'd1, 4'd1, 4'd1, 1, 4'd1, 1);
    checkVal("fl_robCount", 32'(robCount), 32'd0);
    checkVal("fl_Tag1", 32'(Tag1), 32'd0);
    checkVal("fl_CmtCount", 32'(CmtCount), 32'd0);
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
